mini_mips_fetch: RTL and testbench
==================================

Name: mini_mips_fetch

Overview:
- Instruction-fetch stage directly upstream of the miniMips datapath core.
- Owns the program counter and reads 16-bit instructions from a synchronous instruction memory.
- Presents each instruction to the core over a valid/ready handshake and accepts PC redirects from the core.
- Stops at a HALT opcode or at the end of the program, and counts accepted instructions.

Parameters:
- AW, 6: PC / instruction-memory address width in bits.
- RESET_PC, 0: PC value loaded on reset and on restart.
- PROG_LEN, 26: number of valid program words. Fetching from pc == PROG_LEN halts instead of issuing a read.
- HALT_OP, 4'b1111: opcode (instr[15:12]) that terminates fetch.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; begins fetch from IDLE, or restarts from HALT.
- imem_en  out  1  instruction-memory read enable.
- imem_addr  out  AW  read address; data returns on imem_rdata one cycle after imem_en.
- imem_rdata  in  16  instruction word from memory.
- instr  out  16  instruction presented to the core.
- instr_valid  out  1  instr holds a valid instruction.
- instr_ready  in  1  core accepts instr this cycle.
- redirect_valid  in  1  core requests a PC change.
- redirect_pc  in  AW  new PC.
- pc  out  AW  PC of the word currently in flight or held.
- halted  out  1  fetch stopped.
- instr_count  out  16  number of accepted handshakes; saturates at 16'hFFFF.

Behaviour:
- Reset, when reset_n == 0 at a clock edge:
  - state = IDLE, pc = RESET_PC, instr = 0, instr_valid = 0, imem_en = 0, halted = 0, instr_count = 0.
  - Reset has priority over every other input, including mid-operation. Any held instruction is discarded.
- States: IDLE, REQ, WAIT, HOLD, HALT.
- IDLE: outputs idle. On start go to REQ.
- REQ:
  - If pc == PROG_LEN, go to HALT with no read.
  - Otherwise drive imem_en = 1 and imem_addr = pc, then go to WAIT.
- WAIT:
  - Sample imem_rdata.
  - If imem_rdata[15:12] == HALT_OP, go to HALT. The word is never presented and instr_valid stays 0.
  - Otherwise instr <= imem_rdata, instr_valid <= 1, go to HOLD.
- HOLD:
  - instr and instr_valid are held stable until a handshake (instr_valid && instr_ready).
  - On handshake: instr_valid <= 0, instr_count increments (saturating), pc <= pc + 1, go to REQ.
  - pc + 1 wraps modulo 2^AW.
- Redirect, in REQ, WAIT or HOLD:
  - pc <= redirect_pc, instr_valid <= 0, go to REQ.
  - An in-flight WAIT read is dropped.
  - Redirect overrides pc + 1. If a handshake happens in the same cycle, the instruction still counts as accepted (instr_count increments) but pc takes redirect_pc.
  - Redirect is ignored in IDLE and HALT.
- HALT:
  - halted = 1, instr_valid = 0, imem_en = 0.
  - On start: pc <= RESET_PC, instr_count <= 0, halted <= 0, go to REQ.
- start is ignored in REQ, WAIT and HOLD.
- Latency:
  - start to first instr_valid: 3 cycles (IDLE→REQ, REQ→WAIT, WAIT→HOLD).
  - Steady-state throughput with instr_ready held high: 1 instruction per 3 cycles.
- imem_addr equals pc in every state. Only imem_en qualifies it.

Decomposition:
- Shared package mini_mips_pkg holds:
  - INSTR_W = 16 and the opcode field slice [15:12].
  - Opcode constants, including HALT_OP.
  - The fetch state enum (IDLE, REQ, WAIT, HOLD, HALT).
- No RTL sub-module; the FSM, PC and counter fit in one module.
- The bench uses a separate synchronous ROM model, mini_mips_imem: 1-cycle read, loaded with $readmemb.

Test Plan:
- Straight-line fetch. ROM words 0..2 = 16'h0050, 16'h0098, 16'h00E1; instr_ready = 1; pulse start.
  - instr_valid first rises 3 cycles after start with instr = 16'h0050.
  - Next words follow every 3 cycles; instr_count = 3 after the third handshake.
- Back-pressure. Hold instr_ready = 0 for 5 cycles with instr = 16'h0050 valid.
  - instr stays stable, pc = 0, no imem_en pulses.
  - After instr_ready = 1, pc becomes 1.
- Redirect.
  - In HOLD at pc = 2, assert redirect_valid with redirect_pc = 6'd20 (no handshake): instr_valid drops, the next read is at address 20, instr_count is unchanged.
  - Redirect together with a handshake: instr_count increments and pc = 20.
- HALT opcode. ROM word 4 = 16'hF000.
  - After word 3 is accepted, halted = 1 and instr_valid never rises for word 4.
  - A start pulse restarts at RESET_PC with instr_count = 0.
- Program end. PROG_LEN = 26, no HALT word, all handshakes accepted.
  - After word 25 is accepted, halted = 1 with no read of address 26.
  - instr_count = 26.
- Reset mid-operation. Pull reset_n low for 1 cycle while in HOLD.
  - Next cycle: instr_valid = 0, pc = 0, state IDLE, instr_count = 0.
  - No fetch until start.

Source files
------------

// File: rtl/mini_mips_pkg.sv
// Shared definitions for the miniMips front end: instruction width,
// opcode field, opcode constants and the fetch-stage state encoding.
package mini_mips_pkg;

  localparam int INSTR_W = 16;
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;

  // Opcode constants (instr[15:12]).
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;
  localparam logic [3:0] OP_SW   = 4'b0101;
  localparam logic [3:0] OP_BEQ  = 4'b0110;
  localparam logic [3:0] OP_J    = 4'b0111;
  localparam logic [3:0] HALT_OP = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_HALT = 3'd4
  } fetch_state_e;

  // Extract the opcode field of an instruction word.
  function automatic logic [3:0] opcode_of(input logic [INSTR_W-1:0] word);
    return word[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/mini_mips_fetch.sv
// Instruction-fetch stage: owns the PC, reads a synchronous instruction
// memory, presents words to the core over valid/ready, honours redirects,
// stops on HALT opcode or program end, and counts accepted instructions.
module mini_mips_fetch
  import mini_mips_pkg::*;
#(
  parameter int              AW       = 6,
  parameter logic [AW-1:0]   RESET_PC = {AW{1'b0}},
  parameter int              PROG_LEN = 26,
  parameter logic [3:0]      HALT_OP  = mini_mips_pkg::HALT_OP
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  output logic               imem_en,
  output logic [AW-1:0]      imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [AW-1:0]      redirect_pc,
  output logic [AW-1:0]      pc,
  output logic               halted,
  output logic [15:0]        instr_count
);

  // Fetching from this address ends the program without a read.
  localparam logic [AW-1:0] END_PC = AW'(PROG_LEN);

  fetch_state_e        state_r, state_next_s;
  logic [AW-1:0]       pc_r, pc_next_s, pc_inc_s;
  logic [INSTR_W-1:0]  instr_r, instr_next_s;
  logic                instr_valid_r, instr_valid_next_s;
  logic                imem_en_r, imem_en_next_s;
  logic                halted_r, halted_next_s;
  logic [15:0]         count_r, count_next_s, count_inc_s;
  logic                handshake_s;

  assign handshake_s = instr_valid_r && instr_ready;
  assign pc_inc_s    = pc_r + {{(AW-1){1'b0}}, 1'b1};
  assign count_inc_s = (count_r == 16'hFFFF) ? count_r : (count_r + 16'd1);

  // Next-state, PC, instruction-register and counter decode.
  always_comb begin
    state_next_s       = state_r;
    pc_next_s          = pc_r;
    instr_next_s       = instr_r;
    instr_valid_next_s = instr_valid_r;
    count_next_s       = count_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_next_s = S_REQ;
        end else begin
          state_next_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (redirect_valid) begin
          pc_next_s          = redirect_pc;
          instr_valid_next_s = 1'b0;
          state_next_s       = S_REQ;
        end else if (pc_r == END_PC) begin
          state_next_s = S_HALT;
        end else begin
          state_next_s = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          // The in-flight read is simply dropped.
          pc_next_s          = redirect_pc;
          instr_valid_next_s = 1'b0;
          state_next_s       = S_REQ;
        end else if (opcode_of(imem_rdata) == HALT_OP) begin
          instr_valid_next_s = 1'b0;
          state_next_s       = S_HALT;
        end else begin
          instr_next_s       = imem_rdata;
          instr_valid_next_s = 1'b1;
          state_next_s       = S_HOLD;
        end
      end
      S_HOLD: begin
        // A handshake still counts even when a redirect wins the PC.
        if (handshake_s) begin
          count_next_s = count_inc_s;
        end else begin
          count_next_s = count_r;
        end
        if (redirect_valid) begin
          pc_next_s          = redirect_pc;
          instr_valid_next_s = 1'b0;
          state_next_s       = S_REQ;
        end else if (handshake_s) begin
          pc_next_s          = pc_inc_s;
          instr_valid_next_s = 1'b0;
          state_next_s       = S_REQ;
        end else begin
          state_next_s = S_HOLD;
        end
      end
      S_HALT: begin
        instr_valid_next_s = 1'b0;
        if (start) begin
          pc_next_s    = RESET_PC;
          count_next_s = 16'd0;
          state_next_s = S_REQ;
        end else begin
          state_next_s = S_HALT;
        end
      end
      default: begin
        instr_valid_next_s = 1'b0;
        state_next_s       = S_IDLE;
      end
    endcase
    // Read enable is registered so it is high exactly while in a REQ that reads.
    imem_en_next_s = (state_next_s == S_REQ) && (pc_next_s != END_PC);
    halted_next_s  = (state_next_s == S_HALT);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r       <= S_IDLE;
      pc_r          <= RESET_PC;
      instr_r       <= {INSTR_W{1'b0}};
      instr_valid_r <= 1'b0;
      imem_en_r     <= 1'b0;
      halted_r      <= 1'b0;
      count_r       <= 16'd0;
    end else begin
      state_r       <= state_next_s;
      pc_r          <= pc_next_s;
      instr_r       <= instr_next_s;
      instr_valid_r <= instr_valid_next_s;
      imem_en_r     <= imem_en_next_s;
      halted_r      <= halted_next_s;
      count_r       <= count_next_s;
    end
  end

  assign imem_en     = imem_en_r;
  assign imem_addr   = pc_r;
  assign instr       = instr_r;
  assign instr_valid = instr_valid_r;
  assign pc          = pc_r;
  assign halted      = halted_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_mini_mips_fetch.sv
// Directed bench for mini_mips_fetch with a 1-cycle synchronous ROM model
// and a scoreboard of expected (instr, pc) pairs.
module tb_mini_mips_fetch;

  localparam int AW = 6;

  typedef struct packed {
    logic [15:0]   instr;
    logic [AW-1:0] pc;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_rdata = 16'h0000;
  logic [15:0]   instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic [AW-1:0] pc;
  logic          halted;
  logic [15:0]   instr_count;

  logic [15:0] rom_mem [0:63];
  exp_t        sb_q [$];
  int          tests = 0;
  int          fails = 0;
  int          tick_count = 0;
  int          read_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  logic        read26 = 1'b0;

  mini_mips_fetch #(.AW(AW), .RESET_PC(6'd0), .PROG_LEN(26), .HALT_OP(4'b1111)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears one cycle after the enabled read.
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= rom_mem[imem_addr];
  end

  // Read monitor: counts reads, remembers last address, flags a read of 26.
  always @(posedge clk) begin
    if (imem_en) begin
      read_cnt  <= read_cnt + 1;
      last_addr <= imem_addr;
      if (imem_addr == 6'd26) read26 <= 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      tick_count++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (instr_valid !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    chk("wait_valid", 32'(instr_valid), 32'd1);
  endtask

  task automatic push_word(input int a);
    exp_t e;
    e.instr = rom_mem[a];
    e.pc    = AW'(a);
    sb_q.push_back(e);
  endtask

  task automatic expect_cur(input string tag);
    exp_t e;
    tests++;
    assert (sb_q.size() > 0) else begin
      fails++;
      $error("FAIL %s_sb_empty observed=0 expected=1", tag);
    end
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, "_instr"}, 32'(instr), 32'(e.instr));
      chk({tag, "_pc"}, 32'(pc), 32'(e.pc));
    end
  endtask

  initial begin
    int n;
    int t1;
    int rd0;
    logic ok;

    for (int i = 0; i < 64; i++) rom_mem[i] = 16'h0100 + 16'(i);
    rom_mem[0] = 16'h0050;
    rom_mem[1] = 16'h0098;
    rom_mem[2] = 16'h00E1;
    rom_mem[4] = 16'hF000;

    reset_n = 1'b0; start = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 6'd0;
    tick(3);
    reset_n = 1'b1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_en", 32'(imem_en), 32'd0);

    // Straight-line fetch with latency and back-pressure.
    for (int i = 0; i < 4; i++) push_word(i);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("req_en", 32'(imem_en), 32'd1);
    chk("req_addr", 32'(imem_addr), 32'd0);
    tick(1);
    chk("wait_valid0", 32'(instr_valid), 32'd0);
    tick(1);
    chk("lat3_valid", 32'(instr_valid), 32'd1);
    expect_cur("w0");

    rd0 = read_cnt;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (instr !== 16'h0050 || instr_valid !== 1'b1) ok = 1'b0;
    end
    chk("bp_stable", 32'(ok), 32'd1);
    chk("bp_pc", 32'(pc), 32'd0);
    chk("bp_noread", 32'(read_cnt), 32'(rd0));
    instr_ready = 1'b1;
    tick(1);
    chk("bp_pc_after", 32'(pc), 32'd1);
    chk("bp_count", 32'(instr_count), 32'd1);

    wait_valid(n);
    chk("gap_after_hs", 32'(n), 32'd2);
    expect_cur("w1");
    t1 = tick_count;
    tick(1);
    wait_valid(n);
    chk("period3", 32'(tick_count - t1), 32'd3);
    expect_cur("w2");
    tick(1);
    chk("count3", 32'(instr_count), 32'd3);
    wait_valid(n);
    expect_cur("w3");
    tick(1);

    // HALT opcode at word 4: never presented.
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      if (instr_valid !== 1'b0) ok = 1'b0;
    end
    chk("halt_novalid", 32'(ok), 32'd1);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_count", 32'(instr_count), 32'd4);
    chk("halt_pc", 32'(pc), 32'd4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("restart_halted", 32'(halted), 32'd0);
    chk("restart_pc", 32'(pc), 32'd0);
    chk("restart_count", 32'(instr_count), 32'd0);
    chk("restart_en", 32'(imem_en), 32'd1);

    // Redirect without and with handshake.
    for (int i = 0; i < 3; i++) push_word(i);
    push_word(20);
    push_word(20);
    wait_valid(n); expect_cur("r0"); tick(1);
    wait_valid(n); expect_cur("r1"); tick(1);
    wait_valid(n); expect_cur("r2");
    instr_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 6'd20;
    tick(1);
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(instr_valid), 32'd0);
    chk("redir_pc", 32'(pc), 32'd20);
    chk("redir_count", 32'(instr_count), 32'd2);
    wait_valid(n);
    chk("redir_addr", 32'(last_addr), 32'd20);
    expect_cur("r20");
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 6'd20;
    tick(1);
    redirect_valid = 1'b0;
    chk("redir_hs_count", 32'(instr_count), 32'd3);
    chk("redir_hs_pc", 32'(pc), 32'd20);

    // Reset while holding an instruction.
    wait_valid(n);
    expect_cur("r20b");
    reset_n = 1'b0;
    tick(1);
    reset_n = 1'b1;
    chk("mrst_valid", 32'(instr_valid), 32'd0);
    chk("mrst_pc", 32'(pc), 32'd0);
    chk("mrst_count", 32'(instr_count), 32'd0);
    chk("mrst_en", 32'(imem_en), 32'd0);
    rd0 = read_cnt;
    tick(5);
    chk("mrst_idle_noread", 32'(read_cnt), 32'(rd0));
    chk("mrst_idle_valid", 32'(instr_valid), 32'd0);

    // Program end: 26 words, no HALT opcode.
    rom_mem[4] = 16'h0104;
    for (int i = 0; i < 26; i++) push_word(i);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    for (int i = 0; i < 26; i++) begin
      wait_valid(n);
      expect_cur("end");
      tick(1);
    end
    tick(6);
    chk("end_halted", 32'(halted), 32'd1);
    chk("end_count", 32'(instr_count), 32'd26);
    chk("end_pc", 32'(pc), 32'd26);
    chk("end_no_read26", 32'(read26), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
